// File: rtl/demux_route_fifo_pkg.sv
// Shared constants for the result-routing demux and its companion select mux.
package demux_route_fifo_pkg;
  localparam int   DATA_W    = 16;
  localparam int   NUM_PORTS = 2;
  localparam logic PORT_A    = 1'b0;
  localparam logic PORT_B    = 1'b1;
endpackage

// File: rtl/demux_route_fifo_sync_fifo.sv
// Single-clock FIFO with registered count; the head is always presented on rdata.
module sync_fifo
  import demux_route_fifo_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        push_ok, pop_ok;

  // Guard here as well so a caller that ignores full/empty cannot corrupt state.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end
endmodule

// File: rtl/demux_route_fifo.sv
// 1:2 valid/ready demux: steers the producer stream by sel into per-port FIFOs.
module demux_route_fifo
  import demux_route_fifo_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out_A,
  output logic             out_valid_A,
  input  logic             out_ready_A,
  output logic [WIDTH-1:0] data_out_B,
  output logic             out_valid_B,
  input  logic             out_ready_B
);
  logic [NUM_PORTS-1:0]            push, pop, empty, full, out_rdy;
  logic [NUM_PORTS-1:0][WIDTH-1:0] rdata;

  // Ready looks only at registered fullness: a same-cycle pop never frees a slot.
  assign in_ready = ~full[sel];
  assign out_rdy  = {out_ready_B, out_ready_A};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    localparam logic PSEL = 1'(p);
    assign push[p] = in_valid & in_ready & (sel == PSEL);
    assign pop[p]  = out_rdy[p] & ~empty[p];

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[p]),
      .pop   (pop[p]),
      .wdata (data_in),
      .rdata (rdata[p]),
      .empty (empty[p]),
      .full  (full[p])
    );
  end

  assign data_out_A  = rdata[PORT_A];
  assign out_valid_A = ~empty[PORT_A];
  assign data_out_B  = rdata[PORT_B];
  assign out_valid_B = ~empty[PORT_B];
endmodule
